// File: rtl/evaluador_condicion_pkg.sv
// Shared ALU flag definitions and branch/predication condition codes.
package evaluador_condicion_pkg;

  localparam int IDX_N = 0;
  localparam int IDX_Z = 1;
  localparam int IDX_C = 2;
  localparam int IDX_V = 3;

  typedef logic [3:0] flags_t;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

endpackage

// File: rtl/evaluador_condicion_decodificador.sv
// Combinational condition evaluation: (flags, code) -> taken.
module decodificador_condicion
  import evaluador_condicion_pkg::*;
(
  input  flags_t     banderas,
  input  logic [3:0] codigo,
  output logic       tomada
);

  logic n, z, c, v;

  assign n = banderas[IDX_N];
  assign z = banderas[IDX_Z];
  assign c = banderas[IDX_C];
  assign v = banderas[IDX_V];

  always_comb begin
    tomada = 1'b0;
    unique case (cond_e'(codigo))
      EQ: tomada = z;
      NE: tomada = !z;
      CS: tomada = c;
      CC: tomada = !c;
      MI: tomada = n;
      PL: tomada = !n;
      VS: tomada = v;
      VC: tomada = !v;
      HI: tomada = c && !z;
      LS: tomada = !c || z;
      GE: tomada = (n == v);
      LT: tomada = (n != v);
      GT: tomada = !z && (n == v);
      LE: tomada = z || (n != v);
      AL: tomada = 1'b1;
      NV: tomada = 1'b0;
    endcase
  end

endmodule

// File: rtl/evaluador_condicion.sv
// Flag register + condition evaluator with a one-entry result register.
// Define FLAG_FORWARD_EN to evaluate same-edge flag writes with the new flags.
module evaluador_condicion
  import evaluador_condicion_pkg::*;
#(
  parameter int ANCHO_ETIQUETA = 4,
  parameter int ANCHO_CONTADOR = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  flags_t                    banderas,
  input  logic                      escribir_banderas,
  input  logic                      cond_valid,
  output logic                      cond_ready,
  input  logic [3:0]                cond_codigo,
  input  logic [ANCHO_ETIQUETA-1:0] cond_etiqueta,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_tomada,
  output logic [ANCHO_ETIQUETA-1:0] res_etiqueta,
  output flags_t                    banderas_reg,
  output logic [ANCHO_CONTADOR-1:0] conteo_tomadas
);

  flags_t banderas_eval;
  logic   acepta;
  logic   tomada;

  assign cond_ready = !res_valid || res_ready;
  assign acepta     = cond_valid && cond_ready;

`ifdef FLAG_FORWARD_EN
  assign banderas_eval = escribir_banderas ? banderas : banderas_reg;
`else
  assign banderas_eval = banderas_reg;
`endif

  decodificador_condicion u_dec (
    .banderas (banderas_eval),
    .codigo   (cond_codigo),
    .tomada   (tomada)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      banderas_reg <= '0;
    end else if (escribir_banderas) begin
      banderas_reg <= banderas;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_tomada   <= 1'b0;
      res_etiqueta <= '0;
    end else if (acepta) begin
      res_valid    <= 1'b1;
      res_tomada   <= tomada;
      res_etiqueta <= cond_etiqueta;
    end else if (res_ready) begin
      res_valid    <= 1'b0;
    end
  end

  // Saturates at all-ones so a long run never reads back as small.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conteo_tomadas <= '0;
    end else if (acepta && tomada && (conteo_tomadas != '1)) begin
      conteo_tomadas <= conteo_tomadas + ANCHO_CONTADOR'(1);
    end
  end

endmodule
